// File: rtl/cr_xp10_decomp_be_ob_arb.sv
// XP10 decompressor back-end output arbiter: merges the pass-through and LZ
// TLV streams into one output stream, granting whole SOT..EOT frames per source.
`timescale 1ns/1ps

package cr_xp10_decomp_be_ob_arb_pkg;
    typedef struct packed {
        logic        insert;
        logic [12:0] ordern;
        logic [7:0]  typen;
        logic        sot;
        logic        eot;
        logic        tlast;
        logic        tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;
endpackage

module cr_xp10_decomp_be_ob_arb
    import cr_xp10_decomp_be_ob_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sw_ARB_MODE,
    input  logic                             pt_empty,
    input  logic [$bits(tlvp_if_bus_t)-1:0]  pt_tlv,
    output logic                             pt_rd,
    input  logic                             lz_empty,
    input  logic [$bits(tlvp_if_bus_t)-1:0]  lz_tlv,
    output logic                             lz_rd,
    input  logic                             ob_afull,
    output logic                             ob_wr,
    output logic [$bits(tlvp_if_bus_t)-1:0]  ob_tlv,
    output logic                             ob_src,
    output logic [CNT_W-1:0]                 pt_frm_cnt,
    output logic [CNT_W-1:0]                 lz_frm_cnt,
    output logic                             proto_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PT_FRM = 2'd1,
        LZ_FRM = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         last_src_q, last_src_d;
    logic         first_q, first_d;
    logic         ob_wr_q, ob_wr_d;
    tlvp_if_bus_t ob_tlv_q, ob_tlv_d;
    logic         ob_src_q, ob_src_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic [CNT_W-1:0] lz_cnt_q, lz_cnt_d;
    logic         err_q, err_d;

    logic         pt_rd_c, lz_rd_c, pop, pop_src;
    tlvp_if_bus_t pop_word;

    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        first_d    = first_q;
        err_d      = err_q;
        pt_rd_c    = 1'b0;
        lz_rd_c    = 1'b0;
        pop_src    = (state_q == LZ_FRM);
        pop_word   = pop_src ? tlvp_if_bus_t'(lz_tlv) : tlvp_if_bus_t'(pt_tlv);

        case (state_q)
            IDLE: begin
                // Round-robin hands the tie to the source that did not go last.
                first_d = 1'b1;
                if (!pt_empty && !lz_empty)
                    state_d = (sw_ARB_MODE || !last_src_q) ? LZ_FRM : PT_FRM;
                else if (!pt_empty)
                    state_d = PT_FRM;
                else if (!lz_empty)
                    state_d = LZ_FRM;
            end
            PT_FRM:  pt_rd_c = !pt_empty && !ob_afull;
            LZ_FRM:  lz_rd_c = !lz_empty && !ob_afull;
            default: state_d = IDLE;
        endcase

        pop = pt_rd_c || lz_rd_c;
        if (pop) begin
            // First word must carry sot, later words must not.
            first_d = 1'b0;
            if (first_q != pop_word.sot)
                err_d = 1'b1;
            if (pop_word.eot) begin
                state_d    = IDLE;
                last_src_d = pop_src;
            end
        end

        ob_wr_d  = pop;
        ob_tlv_d = pop ? pop_word : ob_tlv_q;
        ob_src_d = pop ? pop_src  : ob_src_q;

        pt_cnt_d = pt_cnt_q;
        lz_cnt_d = lz_cnt_q;
        if (ob_wr_q && ob_tlv_q.eot) begin
            if (ob_src_q) lz_cnt_d = lz_cnt_q + CNT_W'(1);
            else          pt_cnt_d = pt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_src_q <= 1'b1;
            first_q    <= 1'b0;
            ob_wr_q    <= 1'b0;
            ob_tlv_q   <= '0;
            ob_src_q   <= 1'b0;
            pt_cnt_q   <= '0;
            lz_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            first_q    <= first_d;
            ob_wr_q    <= ob_wr_d;
            ob_tlv_q   <= ob_tlv_d;
            ob_src_q   <= ob_src_d;
            pt_cnt_q   <= pt_cnt_d;
            lz_cnt_q   <= lz_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pt_rd      = pt_rd_c && !rst;
    assign lz_rd      = lz_rd_c && !rst;
    assign ob_wr      = ob_wr_q;
    assign ob_tlv     = ob_tlv_q;
    assign ob_src     = ob_src_q;
    assign pt_frm_cnt = pt_cnt_q;
    assign lz_frm_cnt = lz_cnt_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_cr_xp10_decomp_be_ob_arb.sv
// Scoreboard bench for the XP10 output arbiter: show-ahead FIFO models feed
// both sources, expected words are queued in predicted arbitration order.
`timescale 1ns/1ps

module tb_cr_xp10_decomp_be_ob_arb;
    import cr_xp10_decomp_be_ob_arb_pkg::*;

    localparam int CNT_W = 2;
    localparam int TW    = $bits(tlvp_if_bus_t);

    typedef struct {
        logic          src;
        logic [TW-1:0] tlv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_ARB_MODE = 1'b0;
    logic pt_empty = 1'b1, lz_empty = 1'b1, ob_afull = 1'b0;
    logic [TW-1:0] pt_tlv = '0, lz_tlv = '0;
    logic pt_rd, lz_rd, ob_wr, ob_src, proto_err;
    logic [TW-1:0] ob_tlv;
    logic [CNT_W-1:0] pt_frm_cnt, lz_frm_cnt;

    cr_xp10_decomp_be_ob_arb #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sw_ARB_MODE(sw_ARB_MODE),
        .pt_empty(pt_empty), .pt_tlv(pt_tlv), .pt_rd(pt_rd),
        .lz_empty(lz_empty), .lz_tlv(lz_tlv), .lz_rd(lz_rd),
        .ob_afull(ob_afull), .ob_wr(ob_wr), .ob_tlv(ob_tlv), .ob_src(ob_src),
        .pt_frm_cnt(pt_frm_cnt), .lz_frm_cnt(lz_frm_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    tlvp_if_bus_t pt_q[$], lz_q[$];
    exp_t         exp_q[$];
    logic [CNT_W-1:0] m_pt_cnt, m_lz_cnt;
    logic pt_hold = 1'b0, lz_hold = 1'b0, afull_v = 1'b0;
    logic rd_pt, rd_lz, prev_eot;
    int   n_chk = 0, n_fail = 0, idle_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // ek: 0 legal, 1 first word lacks sot, 2 extra sot on word 1
    function automatic tlvp_if_bus_t gen_word(input logic src, input int tag, input int i,
                                              input int n, input int ek);
        tlvp_if_bus_t w;
        logic [63:0]  d;
        d = {8'hA5, 7'd0, src, 16'(tag), 16'(i), 16'hBEEF};
        w = '0;
        w.sot    = (i == 0) ? (ek != 1) : (ek == 2 && i == 1);
        w.eot    = (i == n - 1);
        w.tlast  = w.eot;
        w.tid    = src;
        w.typen  = 8'(tag + 3);
        w.ordern = 13'(i * 7 + tag);
        w.tstrb  = 8'hff ^ 8'(i);
        w.tuser  = d[23:16] ^ 8'h5a;
        w.tdata  = d;
        return w;
    endfunction

    task automatic add_frame(input logic src, input int n, input int tag, input int ek);
        for (int i = 0; i < n; i++) begin
            if (src) lz_q.push_back(gen_word(src, tag, i, n, ek));
            else     pt_q.push_back(gen_word(src, tag, i, n, ek));
        end
    endtask

    task automatic exp_frame(input logic src, input int n, input int tag, input int ek);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.src = src;
            e.tlv = gen_word(src, tag, i, n, ek);
            exp_q.push_back(e);
        end
        if (src) m_lz_cnt = m_lz_cnt + 1'b1;
        else     m_pt_cnt = m_pt_cnt + 1'b1;
    endtask

    task automatic step();
        tlvp_if_bus_t w;
        exp_t e;
        @(negedge clk);
        pt_empty = pt_hold || (pt_q.size() == 0);
        lz_empty = lz_hold || (lz_q.size() == 0);
        pt_tlv   = (pt_q.size() != 0) ? pt_q[0] : '0;
        lz_tlv   = (lz_q.size() != 0) ? lz_q[0] : '0;
        ob_afull = afull_v;
        #1;
        rd_pt = pt_rd;
        rd_lz = lz_rd;
        chk("rd_onehot", 128'(rd_pt & rd_lz), 128'd0);
        if (ob_afull) chk("rd_afull", 128'(rd_pt | rd_lz), 128'd0);
        if (pt_empty) chk("pt_rd_empty", 128'(rd_pt), 128'd0);
        if (lz_empty) chk("lz_rd_empty", 128'(rd_lz), 128'd0);
        if (prev_eot) chk("bubble", 128'(rd_pt | rd_lz), 128'd0);
        if (!rd_pt && !rd_lz && !ob_afull && (!pt_empty || !lz_empty)) idle_cnt++;
        @(posedge clk);
        #1;
        chk("ob_wr_lat", 128'(ob_wr), 128'(rd_pt | rd_lz));
        prev_eot = 1'b0;
        if (rd_pt) begin w = pt_q.pop_front(); prev_eot = w.eot; end
        if (rd_lz) begin w = lz_q.pop_front(); prev_eot = w.eot; end
        if (ob_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ob_src", 128'(ob_src), 128'(e.src));
                chk("ob_tlv", 128'(ob_tlv), 128'(e.tlv));
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pt_q.size() != 0 || lz_q.size() != 0) && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) chk("drain_timeout", 128'd1, 128'd0);
        step();
        step();
        chk("pt_frm_cnt", 128'(pt_frm_cnt), 128'(m_pt_cnt));
        chk("lz_frm_cnt", 128'(lz_frm_cnt), 128'(m_lz_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ob_wr", 128'(ob_wr), 128'd0);
        chk("rst_ob_tlv", 128'(ob_tlv), 128'd0);
        chk("rst_ob_src", 128'(ob_src), 128'd0);
        chk("rst_cnt", 128'({pt_frm_cnt, lz_frm_cnt}), 128'd0);
        chk("rst_err", 128'(proto_err), 128'd0);
        chk("rst_rd", 128'({pt_rd, lz_rd}), 128'd0);
        pt_q.delete();
        lz_q.delete();
        exp_q.delete();
        m_pt_cnt = '0;
        m_lz_cnt = '0;
        pt_hold = 1'b0; lz_hold = 1'b0; afull_v = 1'b0;
        prev_eot = 1'b0;
        idle_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_pt_cnt = '0; m_lz_cnt = '0; prev_eot = 1'b0;
        rd_pt = 1'b0; rd_lz = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // single 4-word PT frame
        add_frame(1'b0, 4, 1, 0);
        exp_frame(1'b0, 4, 1, 0);
        step();
        chk("t1_idle", 128'(rd_pt | rd_lz), 128'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_pt_rd", 128'(rd_pt), 128'd1);
        end
        drain();
        chk("t1_err", 128'(proto_err), 128'd0);
        chk("t1_idle_cnt", 128'(idle_cnt), 128'd1);

        // round-robin with 3 frames preloaded per source
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_frame(1'b0, 2 + f, 10 + f, 0);
            add_frame(1'b1, 3, 20 + f, 0);
        end
        for (int f = 0; f < 3; f++) begin
            exp_frame(1'b0, 2 + f, 10 + f, 0);
            exp_frame(1'b1, 3, 20 + f, 0);
        end
        drain();
        chk("rr_idle_cnt", 128'(idle_cnt), 128'd6);
        chk("rr_err", 128'(proto_err), 128'd0);

        // strict LZ priority
        do_reset();
        sw_ARB_MODE = 1'b1;
        for (int f = 0; f < 3; f++) begin
            add_frame(1'b0, 2, 30 + f, 0);
            add_frame(1'b1, 2 + f, 40 + f, 0);
        end
        for (int f = 0; f < 3; f++) exp_frame(1'b1, 2 + f, 40 + f, 0);
        for (int f = 0; f < 3; f++) exp_frame(1'b0, 2, 30 + f, 0);
        drain();
        chk("pri_idle_cnt", 128'(idle_cnt), 128'd6);
        sw_ARB_MODE = 1'b0;

        // LZ source runs dry mid-frame, then downstream backpressure
        do_reset();
        add_frame(1'b1, 6, 50, 0);
        exp_frame(1'b1, 6, 50, 0);
        repeat (3) step();
        lz_hold = 1'b1;
        add_frame(1'b0, 3, 51, 0);
        exp_frame(1'b0, 3, 51, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) afull_v = 1'b1;
            step();
            chk("stall_no_pt", 128'(rd_pt), 128'd0);
        end
        lz_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("afull_no_lz", 128'(rd_lz), 128'd0);
        end
        afull_v = 1'b0;
        drain();
        chk("stall_err", 128'(proto_err), 128'd0);

        // framing: legal single-word frame, then missing sot, then stray sot
        do_reset();
        add_frame(1'b0, 1, 60, 0);
        exp_frame(1'b0, 1, 60, 0);
        add_frame(1'b1, 1, 61, 0);
        exp_frame(1'b1, 1, 61, 0);
        drain();
        chk("single_word_err", 128'(proto_err), 128'd0);
        add_frame(1'b0, 3, 62, 1);
        exp_frame(1'b0, 3, 62, 1);
        drain();
        chk("no_sot_err", 128'(proto_err), 128'd1);
        do_reset();
        add_frame(1'b1, 4, 63, 2);
        exp_frame(1'b1, 4, 63, 2);
        drain();
        chk("mid_sot_err", 128'(proto_err), 128'd1);

        // counter wrap: 5 LZ frames on a 2-bit counter
        do_reset();
        for (int f = 0; f < 5; f++) begin
            add_frame(1'b1, 1 + (f % 2), 70 + f, 0);
            exp_frame(1'b1, 1 + (f % 2), 70 + f, 0);
        end
        drain();
        chk("lz_wrap", 128'(lz_frm_cnt), 128'd1);

        // reset mid-frame, then PT must win the first tie
        add_frame(1'b0, 6, 80, 0);
        exp_frame(1'b0, 6, 80, 0);
        repeat (3) step();
        do_reset();
        add_frame(1'b1, 2, 81, 0);
        add_frame(1'b0, 2, 82, 0);
        exp_frame(1'b0, 2, 82, 0);
        exp_frame(1'b1, 2, 81, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=done", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cr_xp10_decomp_be_ob_arb.md
# cr_xp10_decomp_be_ob_arb

Frame-atomic output arbiter for the XP10 decompressor back end. Merges the pass-through FIFO stream and the LZ data/footer stream into one TLV output stream toward the output buffer, granting whole frames (SOT..EOT) to one source at a time. Selection is round-robin, or optionally strict LZ priority. The block also checks SOT/EOT framing and counts completed frames per source.

## Interface
Parameters:
- CNT_W, 16, width of per-source frame counters (wrap-around)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- sw_ARB_MODE  in  1  0 = round-robin, 1 = strict LZ priority; sampled only in IDLE
- pt_empty  in  1  pass-through FIFO empty (show-ahead FIFO, pt_tlv valid when !pt_empty)
- pt_tlv  in  $bits(tlvp_if_bus_t)  pass-through head word
- pt_rd  out  1  pop pass-through FIFO
- lz_empty  in  1  LZ data FIFO empty (show-ahead)
- lz_tlv  in  $bits(tlvp_if_bus_t)  LZ head word
- lz_rd  out  1  pop LZ FIFO
- ob_afull  in  1  downstream has ≤2 free slots
- ob_wr  out  1  output write strobe (registered)
- ob_tlv  out  $bits(tlvp_if_bus_t)  output word (registered)
- ob_src  out  1  source of the word on ob_tlv: 0 = PT, 1 = LZ
- pt_frm_cnt  out  CNT_W  PT frames completed
- lz_frm_cnt  out  CNT_W  LZ frames completed
- proto_err  out  1  sticky framing-error flag

## Operation
- States: IDLE, PT_FRM, LZ_FRM. The FSM holds a 1-bit last_src, with reset value 1 (LZ), so PT wins the first tie.
- IDLE arbitration:
  - Only one of pt_empty/lz_empty low → go to that source's state.
  - Both low, round-robin → go to the source ≠ last_src.
  - Both low, sw_ARB_MODE=1 → go to LZ_FRM.
  - Both empty → stay in IDLE.
- IDLE never pops a FIFO.
- PT_FRM: pt_rd = !pt_empty && !ob_afull. lz_rd = 0.
- LZ_FRM: lz_rd = !lz_empty && !ob_afull. pt_rd = 0.
- The read strobe is combinational from state and inputs.
- Popping a word with eot=1 → state returns to IDLE next cycle, and last_src takes the granted source.
- An empty source mid-frame keeps the grant (no preemption). Waiting words on the other source stall until EOT.
- Framing check, using a first-word flag set on frame grant and cleared on the first pop:
  - First popped word with sot=0 → proto_err.
  - Any later word in the frame with sot=1 → proto_err.
  - A word with sot=1 and eot=1 is a legal single-word frame.
- proto_err is sticky until rst. Erroneous words are still forwarded unchanged.
- Counters:
  - pt_frm_cnt / lz_frm_cnt increment when ob_wr=1 and ob_tlv.eot=1, for the source given by ob_src.
  - Counters are CNT_W bits and wrap from all-ones to 0 with no flag.
- The data word is never modified; the arbiter forwards tdata/tuser/tstrb and all other fields as-is.

## Timing
- Reset values: ob_wr=0, ob_tlv='0, ob_src=0, pt_frm_cnt=0, lz_frm_cnt=0, proto_err=0, state=IDLE, last_src=1.
- pt_rd and lz_rd are 0 during reset and in IDLE.
- Latency: pop at cycle N → ob_wr=1 with that word at cycle N+1. ob_src is registered alongside.
- Per-frame overhead: exactly one IDLE bubble cycle between the EOT pop and the next frame's first pop. Frames run back-to-back at one frame plus one bubble when both sources are full.
- Throughput within a frame: one word/cycle while the source is non-empty and ob_afull=0.
- ob_afull rises at cycle N → no pop at N. The in-flight word from N-1 is still written at N. The 2-slot margin absorbs this.
- Source empty and ob_afull in the same cycle → no pop, no state change.
- sw_ARB_MODE changes mid-frame take effect at the next IDLE decision only.
- Reset mid-frame: all state is cleared immediately. The partial frame is truncated, and downstream recovery is out of scope. No pop in the reset cycle.
- Counter increments coincide with the ob_wr EOT cycle and are visible at N+2 relative to the EOT pop.

## Test plan
- Single PT frame of 4 words (sot on word0, eot on word3), LZ empty, ob_afull=0:
  - IDLE 1 cycle, pt_rd for 4 cycles, ob_wr 4 cycles starting 1 cycle later, ob_src=0.
  - pt_frm_cnt=1 and proto_err=0 afterwards.
- Both sources preloaded with 3 frames each, round-robin:
  - Output order PT,LZ,PT,LZ,PT,LZ, one bubble between frames, no interleaving of words.
  - Both counters=3.
- Same preload with sw_ARB_MODE=1: all 3 LZ frames are output first, then 3 PT frames.
- LZ frame mid-transfer: drop lz_empty for 5 cycles while the PT FIFO holds a frame → no PT pop until the LZ eot word is output. ob_afull pulse for 3 cycles → no lz_rd in those cycles and no word lost.
- Framing errors:
  - A frame whose first word has sot=0 → proto_err=1, frame still forwarded.
  - A word with sot=1 mid-frame also sets proto_err.
  - A single word with sot=eot=1 → no error.
- Counter wrap and reset:
  - With CNT_W=2, 5 LZ frames → lz_frm_cnt=1.
  - Assert rst mid-frame → all outputs 0 in the same cycle; after release, PT wins the first tie.
